aes_inv_round_lin: RTL and testbench
====================================

// Module: aes_inv_round_lin
// PURPOSE
//  Sequential linear half of an AES decryption round: InvShiftRows -> AddRoundKey -> InvMixColumns.
//  Sits after the InvSubBytes stage in the decrypt datapath; InvSubBytes commutes with
//  InvShiftRows, so the input state arrives already inverse-substituted.
//  Valid/ready on both sides; InvMixColumns runs column-serial (one column per cycle).
// PARAMETERS
//  STATE_W  128  state/key width; any value other than 128 is an elaboration error
//  KEY_EN   1    1: XOR round key; 0: in_key ignored (AddRoundKey bypassed)
// PORTS
//  clk        in   1    single clock, rising edge
//  rst_n      in   1    asynchronous, active-low reset
//  in_valid   in   1    input state/key/last valid
//  in_ready   out  1    block can accept (high only in IDLE)
//  in_state   in   128  state after InvSubBytes
//  in_key     in   128  round key
//  in_last    in   1    1 = final round: skip InvMixColumns
//  out_valid  out  1    result valid
//  out_ready  in   1    downstream accepts
//  out_state  out  128  result state
// BEHAVIOUR
//  Byte map: byte i = bits [127-8i -: 8], i = 4*c + r (column-major, row r, col c).
//  InvShiftRows: t(r,c) = in(r,(c-r) mod 4), e.g. t(1,0)=in(1,3), so out bits [119:112] <- in[23:16].
//  InvMixColumns per column [a0..a3]: b_r = 0e*a_r ^ 0b*a_(r+1) ^ 0d*a_(r+2) ^ 09*a_(r+3), GF(2^8), poly 0x11b.
//  FSM states: IDLE -> XK -> MIX (col counter 0..3) -> HOLD -> IDLE.
//   IDLE: in_ready=1. On in_valid: capture state/key/last, go to XK.
//   XK: work = InvShiftRows(state) ^ key (^ 0 if KEY_EN=0). If last=1, go to HOLD; else go to MIX with col=0.
//   MIX: replace column col of work by InvMixColumns(column). col++. After col=3, go to HOLD.
//   HOLD: out_valid=1, out_state=work. Leave only on out_ready, then return to IDLE.
//  Latency: accept edge T; out_valid rises after edge T+2 (last=1) or T+6 (last=0).
//  Throughput: no overlap; in_ready low from the accept edge until the cycle after the out handshake.
//  out_state is stable while out_valid=1 && out_ready=0; it changes only in XK/MIX.
//  out_ready high before out_valid has no effect; in_valid outside IDLE is ignored (no capture).
//  Simultaneous out handshake and in_valid: the new input is not accepted that cycle (in_ready=0).
//  Column counter wraps 3->0 only through HOLD; it is never re-entered mid-column.
//  Reset (any state, mid-operation): state=IDLE, col=0, work=0, out_state=0, out_valid=0, in_ready=0.
//   in_ready rises on the first clock edge after rst_n deasserts. The in-flight operation is dropped.
// CONFIGURATION
//  AES_INV_PAR_MIX_EN defined: MIX processes all 4 columns in one cycle.
//   Latency for last=0 becomes T+3; FSM is IDLE -> XK -> MIX -> HOLD, and col is unused (held 0).
//  Undefined (default): column-serial MIX as above, one GF multiplier column set (smaller area).
//  Results are bit-identical in both builds; only the timing differs.
// TESTING
//  1. InvMixColumns vector: in_state col0=8e4da1bc, rest 0, key=0, last=0, InvShiftRows-neutral
//     layout -> out col0=db135345; second column 9fdc589d -> f20a225c.
//  2. InvShiftRows only: in_state=00010203..0e0f, key=0, last=1
//     -> out=000d0a0704010e0b080502 0f0c0906030 pattern per t(r,c) rule (bytes 00 0d 0a 07 04 01 0e 0b 08 05 02 0f 0c 09 06 03).
//  3. AddRoundKey: same as 2 with key=ffff..ff, last=1 -> bytewise complement of test 2 result;
//     with KEY_EN=0 -> test 2 result.
//  4. Latency/backpressure: last=0, out_ready=0 for 10 cycles -> out_valid at T+6 (T+3 with macro),
//     out_state stable, in_ready=0 throughout. Raise out_ready -> in_ready=1 on the next cycle.
//  5. Reset mid-MIX (col=2): pulse rst_n low -> out_valid=0, out_state=0 immediately (async);
//     in_ready=1 one edge after release; next transaction correct.
//  6. in_valid asserted during MIX/HOLD with a different state -> ignored; output equals the first input's result.

Source files
------------

// File: rtl/aes_inv_round_lin.sv
// Linear half of an AES decrypt round: InvShiftRows -> AddRoundKey -> InvMixColumns.
// Build option AES_INV_PAR_MIX_EN: mix all four columns in one cycle instead of one per cycle.
//
// state | meaning
// IDLE  | waiting for input (in_ready high after the first post-reset edge)
// XK    | work <= InvShiftRows(state) ^ key
// MIX   | InvMixColumns, column-serial (or all columns at once with the macro)
// HOLD  | out_valid raised one cycle after entry, held until out_ready
module aes_inv_round_lin #(
    parameter int STATE_W = 128,
    parameter bit KEY_EN  = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    input  logic [STATE_W-1:0] in_key,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state
);

    if (STATE_W != 128) begin : g_bad_width
        $error("aes_inv_round_lin: STATE_W must be 128");
    end

    typedef enum logic [1:0] {S_IDLE, S_XK, S_MIX, S_HOLD} state_t;

    state_t             r_fsm;
    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] r_key;
    logic               r_last;
    logic [STATE_W-1:0] r_work;
    logic               r_in_ready;
    logic               r_out_valid;
`ifndef AES_INV_PAR_MIX_EN
    logic [1:0]         r_col;
    logic [31:0]        w_col_in;
    logic [31:0]        w_col_out;
`endif

    logic [STATE_W-1:0] w_shift;
    logic [STATE_W-1:0] w_xk;
    logic [STATE_W-1:0] w_mixed;

    function automatic logic [7:0] f_xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] f_inv_mix(input logic [31:0] col);
        logic [3:0][7:0] a, m9, mb, md, me;
        logic [7:0]      x2, x4, x8;
        a  = '0; m9 = '0; mb = '0; md = '0; me = '0;
        for (int r = 0; r < 4; r++) begin
            a[r]  = col[31-8*r -: 8];
            x2    = f_xt(a[r]);
            x4    = f_xt(x2);
            x8    = f_xt(x4);
            m9[r] = x8 ^ a[r];
            mb[r] = x8 ^ x2 ^ a[r];
            md[r] = x8 ^ x4 ^ a[r];
            me[r] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                me[1] ^ mb[2] ^ md[3] ^ m9[0],
                me[2] ^ mb[3] ^ md[0] ^ m9[1],
                me[3] ^ mb[0] ^ md[1] ^ m9[2]};
    endfunction

    // Row r of column c takes the byte from column (c - r) mod 4
    always_comb begin
        w_shift = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_shift[127-8*(4*c+r) -: 8] = r_state[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
    end

    assign w_xk = w_shift ^ (KEY_EN ? r_key : '0);

`ifdef AES_INV_PAR_MIX_EN
    assign w_mixed = {f_inv_mix(r_work[127:96]), f_inv_mix(r_work[95:64]),
                      f_inv_mix(r_work[63:32]),  f_inv_mix(r_work[31:0])};
`else
    always_comb begin
        w_col_in = r_work[127:96];
        case (r_col)
            2'd0: w_col_in = r_work[127:96];
            2'd1: w_col_in = r_work[95:64];
            2'd2: w_col_in = r_work[63:32];
            2'd3: w_col_in = r_work[31:0];
            default: w_col_in = r_work[127:96];
        endcase
    end

    assign w_col_out = f_inv_mix(w_col_in);

    always_comb begin
        w_mixed = r_work;
        case (r_col)
            2'd0: w_mixed[127:96] = w_col_out;
            2'd1: w_mixed[95:64]  = w_col_out;
            2'd2: w_mixed[63:32]  = w_col_out;
            2'd3: w_mixed[31:0]   = w_col_out;
            default: w_mixed = r_work;
        endcase
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm       <= S_IDLE;
            r_state     <= '0;
            r_key       <= '0;
            r_last      <= 1'b0;
            r_work      <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
`ifndef AES_INV_PAR_MIX_EN
            r_col       <= 2'd0;
`endif
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    // in_ready lags reset release by one edge, so accept only once it is high
                    if (in_valid && r_in_ready) begin
                        r_state    <= in_state;
                        r_key      <= in_key;
                        r_last     <= in_last;
                        r_in_ready <= 1'b0;
                        r_fsm      <= S_XK;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                S_XK: begin
                    r_work <= w_xk;
`ifndef AES_INV_PAR_MIX_EN
                    r_col  <= 2'd0;
`endif
                    r_fsm  <= r_last ? S_HOLD : S_MIX;
                end
                S_MIX: begin
                    r_work <= w_mixed;
`ifdef AES_INV_PAR_MIX_EN
                    r_fsm  <= S_HOLD;
`else
                    if (r_col == 2'd3) begin
                        r_col <= 2'd0;
                        r_fsm <= S_HOLD;
                    end else begin
                        r_col <= r_col + 2'd1;
                    end
`endif
                end
                S_HOLD: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_fsm       <= S_IDLE;
                    end
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_state = r_work;

endmodule

// File: tb/tb_aes_inv_round_lin.sv
// Directed bench for aes_inv_round_lin: hand-computed vectors, latency, backpressure, reset.
module tb_aes_inv_round_lin;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_state = '0;
    logic [127:0] in_key = '0;
    logic         in_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_state;

    int n_checks = 0;
    int n_errors = 0;

`ifdef AES_INV_PAR_MIX_EN
    localparam int LAT_MIX = 3;
`else
    localparam int LAT_MIX = 6;
`endif
    localparam int LAT_LAST = 2;

    localparam logic [127:0] ST_SEQ   = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    localparam logic [127:0] EXP_SHR  = 128'h000d0a07_04010e0b_0805020f_0c090603;
    localparam logic [127:0] EXP_NSHR = 128'hfff2f5f8_fbfef1f4_f7fafdf0_f3f6f9fc;
    localparam logic [127:0] ONES     = {128{1'b1}};
    // Columns placed so InvShiftRows gathers 8e4da1bc into col0 and 9fdc589d into col1
    localparam logic [127:0] ST_MIX   = 128'h8edc0000_9f0000bc_0000a19d_004d5800;
    localparam logic [127:0] EXP_MIX  = 128'hdb135345_f20a225c_00000000_00000000;
    localparam logic [127:0] KEY_MIX  = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
    localparam logic [127:0] EXP_KMIX = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;

    aes_inv_round_lin dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_key    (in_key),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] st, input logic [127:0] key, input logic last);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        check("ready_before_send", {127'd0, in_ready}, 128'd1);
        in_state = st;
        in_key   = key;
        in_last  = last;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_state = '0;
        in_key   = '0;
        in_last  = 1'b0;
        check("in_ready_after_accept", {127'd0, in_ready}, 128'd0);
    endtask

    task automatic wait_valid(input int exp_lat, input string tag);
        int k = 0;
        while (k < 20) begin
            tick();
            k++;
            if (out_valid) break;
        end
        check({tag, "_latency"}, 128'(k), 128'(exp_lat));
        check({tag, "_busy_ready"}, {127'd0, in_ready}, 128'd0);
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, "_valid_drop"}, {127'd0, out_valid}, 128'd0);
        check({tag, "_ready_back"}, {127'd0, in_ready}, 128'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        check("rst_in_ready", {127'd0, in_ready}, 128'd0);
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_out_state", out_state, 128'd0);
        #20 rst_n = 1'b1;
        #1 check("ready_before_first_edge", {127'd0, in_ready}, 128'd0);
        tick();
        check("ready_after_release", {127'd0, in_ready}, 128'd1);

        // InvShiftRows only
        send(ST_SEQ, '0, 1'b1);
        wait_valid(LAT_LAST, "shr");
        check("shr_data", out_state, EXP_SHR);
        drain("shr");

        // AddRoundKey with all-ones key
        send(ST_SEQ, ONES, 1'b1);
        wait_valid(LAT_LAST, "ark");
        check("ark_data", out_state, EXP_NSHR);
        drain("ark");

        // InvMixColumns through InvShiftRows
        send(ST_MIX, '0, 1'b0);
        wait_valid(LAT_MIX, "mix");
        check("mix_data", out_state, EXP_MIX);
        drain("mix");

        // All four columns mixed, driven from the key
        send('0, KEY_MIX, 1'b0);
        wait_valid(LAT_MIX, "kmix");
        check("kmix_data", out_state, EXP_KMIX);
        drain("kmix");

        // Backpressure: hold out_ready low for 10 cycles
        send(ST_MIX, '0, 1'b0);
        wait_valid(LAT_MIX, "bp");
        for (int i = 0; i < 10; i++) begin
            check("bp_valid_held", {127'd0, out_valid}, 128'd1);
            check("bp_ready_low", {127'd0, in_ready}, 128'd0);
            check("bp_data_stable", out_state, EXP_MIX);
            tick();
        end
        drain("bp");

        // out_ready high before out_valid has no effect
        out_ready = 1'b1;
        send(ST_SEQ, '0, 1'b1);
        wait_valid(LAT_LAST, "early");
        check("early_data", out_state, EXP_SHR);
        tick();
        out_ready = 1'b0;
        check("early_valid_drop", {127'd0, out_valid}, 128'd0);
        check("early_ready_back", {127'd0, in_ready}, 128'd1);

        // Reset in the middle of the mix
        send(ST_MIX, '0, 1'b0);
        tick();
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {127'd0, out_valid}, 128'd0);
        check("midrst_out_state", out_state, 128'd0);
        check("midrst_in_ready", {127'd0, in_ready}, 128'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1 check("midrst_ready_before_edge", {127'd0, in_ready}, 128'd0);
        tick();
        check("midrst_ready_after_edge", {127'd0, in_ready}, 128'd1);
        send('0, KEY_MIX, 1'b0);
        wait_valid(LAT_MIX, "postrst");
        check("postrst_data", out_state, EXP_KMIX);
        drain("postrst");

        // in_valid while busy is ignored, also on the handshake cycle
        send('0, KEY_MIX, 1'b0);
        in_state = ST_SEQ;
        in_key   = ONES;
        in_last  = 1'b1;
        in_valid = 1'b1;
        wait_valid(LAT_MIX, "busy");
        check("busy_data", out_state, EXP_KMIX);
        drain("busy");
        tick();
        check("busy_no_capture", {127'd0, in_ready}, 128'd1);
        check("busy_no_output", {127'd0, out_valid}, 128'd0);
        in_state = '0;
        in_key   = '0;
        in_last  = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
